mox125_decode: RTL
==================

Name: mox125_decode

Overview:
- Decode stage of the mox125 pipeline, directly upstream of the microcode ROM.
- Consumes the 16-bit halfword stream from fetch and assembles complete moxie instructions, including the optional trailing 32-bit immediate (big-endian, high halfword first).
- Presents a registered, field-split instruction to execute. opcode_o drives the microcode ROM opcode input.
- Valid/ready on the fetch side. Valid/stall on the execute side. Synchronous flush for taken branches.

Parameters:
- LONG_IMM_MASK, 64-bit, default has bits set at 0x01,0x03,0x08,0x09,0x0c,0x0d,0x1a,0x1b,0x1d,0x1f,0x20,0x22,0x23,0x36,0x37,0x38,0x39 and all others clear. Bit n set means form-1 opcode n carries a 32-bit immediate.

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard partial and held instruction
- fetch_valid_i  in  1  fetch_data_i/fetch_pc_i valid
- fetch_data_i  in  16  instruction halfword
- fetch_pc_i  in  32  address of fetch_data_i
- fetch_ready_o  out  1  decode accepts halfword this cycle
- stall_i  in  1  execute cannot accept the held instruction
- valid_o  out  1  output fields hold a complete instruction
- opcode_o  out  8  insn[15:8]; feeds microcode ROM
- reg_a_o  out  4  register A field
- reg_b_o  out  4  register B field
- imm_o  out  32  immediate / offset
- pc_o  out  32  address of first halfword of instruction
- long_o  out  1  instruction was 48 bits

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset: state=S_INSN. valid_o, long_o, opcode_o, reg_a_o, reg_b_o, imm_o and pc_o are all 0. Pending registers are cleared.
- Handshake: a halfword transfers on a clock edge when fetch_valid_i && fetch_ready_o.
- Output register "free": !valid_o || !stall_i.
- fetch_ready_o is 0 when flush_i or rst_i is asserted.
- Otherwise fetch_ready_o = (state==S_IMM_HI) || free. Only S_IMM_HI may accept while the output register is held.
- State S_INSN, on a transfer of halfword h:
  - If h[15]==0 and LONG_IMM_MASK[h[13:8]] is set:
    - Latch h and fetch_pc_i into the pending registers.
    - Go to S_IMM_HI.
  - Otherwise:
    - Load the output register next edge; valid_o=1, long_o=0, pc_o=fetch_pc_i, opcode_o=h[15:8].
    - Form 1 (h[15]=0): reg_a=h[7:4], reg_b=h[3:0], imm=0.
    - Form 2 (h[15:14]=10): reg_a=h[11:8], reg_b=0, imm=zero-extended h[7:0].
    - Form 3 (h[15:14]=11): reg_a=0, reg_b=0, imm=sign-extended h[9:0].
- State S_IMM_HI: on a transfer, latch imm[31:16] and go to S_IMM_LO.
- State S_IMM_LO: on a transfer:
  - Load the output register from the pending halfword (form-1 fields), with imm={imm_hi, data}.
  - Set long_o=1 and pc_o=pending pc; valid_o=1.
  - Go to S_INSN.
- Latency: valid_o rises on the edge of the final halfword transfer. This is 1 cycle for short instructions and 3 halfword transfers for long ones.
- Hold: while valid_o && stall_i, all output fields are stable.
- Drain: if free and no instruction completes this cycle, valid_o goes to 0. Fields may retain their old values.
- Back-to-back: with no stall, short instructions issue one per cycle. Completion and retirement of the previous instruction in the same cycle is legal and keeps valid_o=1.
- Flush (synchronous):
  - Next edge: valid_o=0, state=S_INSN, pending state is discarded.
  - No halfword is consumed in the flush cycle.
  - Flush wins over a simultaneous completion or stall.
- Reset mid-operation (e.g. in S_IMM_LO) behaves like a full reset.
- Bubbles: fetch_valid_i=0 in S_IMM_HI or S_IMM_LO just waits. There is no timeout.

Test Plan:
- Short insn 0x0523 (form 1, opcode 0x05), pc 0x1000, no stall -> next cycle valid_o=1, opcode_o=0x05, reg_a_o=2, reg_b_o=3, imm_o=0, long_o=0, pc_o=0x1000.
- Long insn 0x0120, 0xDEAD, 0xBEEF at pc 0x2000 -> valid_o rises after the third transfer, opcode_o=0x01, reg_a_o=2, imm_o=0xDEADBEEF, long_o=1, pc_o=0x2000.
- Form 3 0xC3FF -> imm_o=0xFFFFFFFF. Form 2 0x8A7F -> reg_a_o=0xA, imm_o=0x0000007F.
- stall_i high for 4 cycles with valid_o=1 and a long insn pending:
  - Outputs stay stable; S_IMM_HI accepts, then fetch_ready_o=0 in S_IMM_LO.
  - After stall_i drops, the new insn appears on the next cycle.
- flush_i asserted in S_IMM_LO with fetch_valid_i=1 -> fetch_ready_o=0 that cycle, then valid_o=0, state S_INSN. Next halfword 0x0523 decodes as a fresh short insn.
- Continuous stream of 8 short insns, no stall -> 8 consecutive valid_o cycles in order. rst_i pulsed mid-stream -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/mox125_decode.sv
// Decode stage: assembles fetched halfwords into moxie instructions (with optional
// trailing 32-bit immediate) and presents a registered, field-split instruction.
module mox125_decode #(
    parameter logic [63:0] LONG_IMM_MASK = 64'h03C0_000D_AC00_330A
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    input  logic [15:0] fetch_data_i,
    input  logic [31:0] fetch_pc_i,
    output logic        fetch_ready_o,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [7:0]  opcode_o,
    output logic [3:0]  reg_a_o,
    output logic [3:0]  reg_b_o,
    output logic [31:0] imm_o,
    output logic [31:0] pc_o,
    output logic        long_o
);

    typedef enum logic [1:0] {
        S_INSN   = 2'd0,
        S_IMM_HI = 2'd1,
        S_IMM_LO = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic        long_q, long_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [3:0]  reg_a_q, reg_a_d;
    logic [3:0]  reg_b_q, reg_b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] pend_insn_q, pend_insn_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [15:0] imm_hi_q, imm_hi_d;

    logic free;
    logic ready;
    logic xfer;

    // Handshake: a halfword moves on a rising edge when fetch_valid_i && fetch_ready_o;
    // the held output retires on a rising edge when valid_o && !stall_i.
    assign free  = !valid_q || !stall_i;
    assign ready = !(flush_i || rst_i) && ((state_q == S_IMM_HI) || free);
    assign xfer  = fetch_valid_i && ready;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        long_d      = long_q;
        opcode_d    = opcode_q;
        reg_a_d     = reg_a_q;
        reg_b_d     = reg_b_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        pend_insn_d = pend_insn_q;
        pend_pc_d   = pend_pc_q;
        imm_hi_d    = imm_hi_q;

        if (flush_i) begin
            valid_d     = 1'b0;
            state_d     = S_INSN;
            pend_insn_d = 16'h0;
            pend_pc_d   = 32'h0;
            imm_hi_d    = 16'h0;
        end else begin
            // Drain by default; a completing instruction below re-asserts valid.
            if (free) begin
                valid_d = 1'b0;
            end
            case (state_q)
                S_INSN: begin
                    if (xfer) begin
                        if (!fetch_data_i[15] && LONG_IMM_MASK[fetch_data_i[13:8]]) begin
                            pend_insn_d = fetch_data_i;
                            pend_pc_d   = fetch_pc_i;
                            state_d     = S_IMM_HI;
                        end else begin
                            valid_d  = 1'b1;
                            long_d   = 1'b0;
                            pc_d     = fetch_pc_i;
                            opcode_d = fetch_data_i[15:8];
                            if (!fetch_data_i[15]) begin
                                reg_a_d = fetch_data_i[7:4];
                                reg_b_d = fetch_data_i[3:0];
                                imm_d   = 32'h0;
                            end else if (!fetch_data_i[14]) begin
                                reg_a_d = fetch_data_i[11:8];
                                reg_b_d = 4'h0;
                                imm_d   = {24'h0, fetch_data_i[7:0]};
                            end else begin
                                reg_a_d = 4'h0;
                                reg_b_d = 4'h0;
                                imm_d   = {{22{fetch_data_i[9]}}, fetch_data_i[9:0]};
                            end
                        end
                    end
                end
                S_IMM_HI: begin
                    if (xfer) begin
                        imm_hi_d = fetch_data_i;
                        state_d  = S_IMM_LO;
                    end
                end
                S_IMM_LO: begin
                    if (xfer) begin
                        valid_d  = 1'b1;
                        long_d   = 1'b1;
                        pc_d     = pend_pc_q;
                        opcode_d = pend_insn_q[15:8];
                        reg_a_d  = pend_insn_q[7:4];
                        reg_b_d  = pend_insn_q[3:0];
                        imm_d    = {imm_hi_q, fetch_data_i};
                        state_d  = S_INSN;
                    end
                end
                default: state_d = S_INSN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_INSN;
            valid_q     <= 1'b0;
            long_q      <= 1'b0;
            opcode_q    <= 8'h0;
            reg_a_q     <= 4'h0;
            reg_b_q     <= 4'h0;
            imm_q       <= 32'h0;
            pc_q        <= 32'h0;
            pend_insn_q <= 16'h0;
            pend_pc_q   <= 32'h0;
            imm_hi_q    <= 16'h0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            long_q      <= long_d;
            opcode_q    <= opcode_d;
            reg_a_q     <= reg_a_d;
            reg_b_q     <= reg_b_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            pend_insn_q <= pend_insn_d;
            pend_pc_q   <= pend_pc_d;
            imm_hi_q    <= imm_hi_d;
        end
    end

    assign fetch_ready_o = ready;
    assign valid_o       = valid_q;
    assign long_o        = long_q;
    assign opcode_o      = opcode_q;
    assign reg_a_o       = reg_a_q;
    assign reg_b_o       = reg_b_q;
    assign imm_o         = imm_q;
    assign pc_o          = pc_q;

endmodule
